// File: rtl/prng_scheduler_pkg.sv
// Shared PRNG defines plus the scheduler package: widths, default refresh and an index-wrap helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef PRNG_STATE_BITS
`define PRNG_STATE_BITS 32
`endif
`ifndef PRNG_REFRESH
`define PRNG_REFRESH `DATA_WIDTH
`endif

package prng_scheduler_pkg;

  localparam int unsigned DATA_WIDTH   = `DATA_WIDTH;
  localparam int unsigned PRNG_REFRESH = `PRNG_REFRESH;

  // Fold an index in [0, 2n-2] back into [0, n-1].
  function automatic int unsigned wrap_idx(input int unsigned i, input int unsigned n);
    return (i >= n) ? (i - n) : i;
  endfunction

endpackage

// File: rtl/prng_scheduler_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
module rr_pick
  import prng_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_c,
  output logic [PTR_W-1:0]   g_c,
  output logic               any_c
);

  always_comb begin
    grant_c = '0;
    g_c     = '0;
    any_c   = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!any_c && req[PTR_W'(wrap_idx(32'(ptr) + off, NUM_REQ))]) begin
        any_c = 1'b1;
        g_c   = PTR_W'(wrap_idx(32'(ptr) + off, NUM_REQ));
        grant_c[PTR_W'(wrap_idx(32'(ptr) + off, NUM_REQ))] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_scheduler.sv
// Hands one PRNG word per grant to NUM_REQ requesters, with a refresh gap between grants,
// and folds requester entropy back into the PRNG.
module prng_scheduler
  import prng_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REFRESH_CYCLES = PRNG_REFRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    ent,
  input  logic [DATA_WIDTH-1:0] prng_random,
  output logic                  prng_entropy,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned AGE_W = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic {S_WAIT, S_READY} state_t;

  state_t                  state_q, state_d;
  logic [AGE_W-1:0]        age_q, age_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]      ack_d;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [NUM_REQ-1:0]      grant_c;
  logic [PTR_W-1:0]        g_c;
  logic                    any_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .grant_c (grant_c),
    .g_c     (g_c),
    .any_c   (any_c)
  );

  // Next state: WAIT counts age up to the refresh length; READY grants one requester.
  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    ptr_d   = ptr_q;
    ack_d   = '0;
    rdata_d = rdata;
    case (state_q)
      S_WAIT: begin
        age_d = age_q + AGE_W'(1);
        if (age_q == AGE_W'(REFRESH_CYCLES - 1)) state_d = S_READY;
      end
      S_READY: begin
        if (any_c) begin
          ack_d   = grant_c;
          rdata_d = prng_random;
          ptr_d   = PTR_W'(wrap_idx(32'(g_c) + 32'd1, NUM_REQ));
          age_d   = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      age_q        <= '0;
      ptr_q        <= '0;
      ack          <= '0;
      rdata        <= '0;
      ready        <= 1'b0;
      prng_entropy <= 1'b0;
    end else begin
      state_q      <= state_d;
      age_q        <= age_d;
      ptr_q        <= ptr_d;
      ack          <= ack_d;
      rdata        <= rdata_d;
      ready        <= (state_d == S_READY);
      prng_entropy <= ^ent;
    end
  end

endmodule

// File: tb/tb_prng_scheduler.sv
// Directed plus randomized bench for prng_scheduler against a countdown/queue-free reference model.
module tb_prng_scheduler;
  import prng_scheduler_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N-1:0]          req = '0;
  logic [N-1:0]          ent = '0;
  logic [DATA_WIDTH-1:0] prng_random = '0;
  logic                  prng_entropy;
  logic [N-1:0]          ack;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: readiness as a countdown of remaining wait cycles.
  bit                    m_ready;
  int                    m_left;
  int                    m_ptr;
  logic [N-1:0]          m_ack;
  logic [DATA_WIDTH-1:0] m_rdata;
  bit                    m_ent;

  prng_scheduler #(.NUM_REQ(N), .REFRESH_CYCLES(R)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .ent          (ent),
    .prng_random  (prng_random),
    .prng_entropy (prng_entropy),
    .ack          (ack),
    .rdata        (rdata),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = R;
    m_ptr   = 0;
    m_ack   = '0;
    m_rdata = '0;
    m_ent   = 1'b0;
  endtask

  task automatic model_edge();
    bit got;
    int g;
    got = 1'b0;
    g   = 0;
    if (m_ready && req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (!got && req[(m_ptr + k) % N]) begin
          got = 1'b1;
          g   = (m_ptr + k) % N;
        end
      end
      m_ack   = N'(1) << g;
      m_rdata = prng_random;
      m_ptr   = (g + 1) % N;
      m_ready = 1'b0;
      m_left  = R;
    end else begin
      m_ack = '0;
      if (!m_ready) begin
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end
    end
    m_ent = ^ent;
  endtask

  // One clock: update model on the edge, compare all outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check("ack", 32'(ack), 32'(m_ack));
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("ready", 32'(ready), 32'(m_ready));
    check("entropy", 32'(prng_entropy), 32'(m_ent));
  endtask

  task automatic wait_ready(input int bound);
    logic seen;
    seen = ready;
    for (int c = 0; c < bound && !seen; c++) begin
      step();
      seen = ready;
    end
    if (!seen) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_ack(input int bound, output logic [N-1:0] a, output int cyc);
    a   = '0;
    cyc = 0;
    for (int c = 1; c <= bound && a == '0; c++) begin
      step();
      if (ack != '0) begin
        a   = ack;
        cyc = c;
      end
    end
    if (a == '0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [N-1:0] a;
    int           cyc;
    int           first;
    int           n;
    logic [N-1:0] exp_order [5];
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;

    // Reset and first READY timing.
    #1 rst_n = 1'b0;
    model_reset();
    step();
    step();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_entropy", 32'(prng_entropy), 32'd0);
    rst_n = 1'b1;
    first = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (ready && first == 0) first = c;
    end
    check("rst_ready_rise", 32'(first), 32'd4);

    // Single request.
    req = 4'b0010;
    prng_random = 16'hBEEF;
    step();
    check("single_ack", 32'(ack), 32'h2);
    check("single_rdata", 32'(rdata), 32'hBEEF);
    req = '0;
    prng_random = 16'h1234;
    n = 0;
    for (int c = 0; c < 10 && !ready; c++) begin
      step();
      n++;
    end
    check("single_wait", 32'(n), 32'd4);
    check("single_hold", 32'(rdata), 32'hBEEF);

    // Async reset mid-WAIT, right after a grant.
    req = 4'b0001;
    prng_random = 16'hCAFE;
    step();
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("async_ack", 32'(ack), 32'd0);
    check("async_rdata", 32'(rdata), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    wait_ready(10);

    // Contention with all four requesting.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      prng_random = 16'($urandom);
      next_ack(12, a, cyc);
      check("cont_order", 32'(a), 32'(exp_order[i]));
      check("cont_gap", 32'(cyc), (i == 0) ? 32'd1 : 32'd5);
    end

    // Skip and wrap: steer ptr to 3, then request 0101.
    req = '0;
    wait_ready(10);
    req = 4'b0100;
    next_ack(2, a, cyc);
    check("steer_ack", 32'(a), 32'h4);
    req = '0;
    wait_ready(10);
    req = 4'b0101;
    next_ack(2, a, cyc);
    check("wrap_first", 32'(a), 32'h1);
    req = 4'b0100;
    next_ack(12, a, cyc);
    check("wrap_second", 32'(a), 32'h4);
    check("wrap_gap", 32'(cyc), 32'd5);

    // Withdrawn request during WAIT leaves no trace.
    req = 4'b1000;
    step();
    step();
    req = '0;
    wait_ready(10);
    req = 4'b0001;
    next_ack(2, a, cyc);
    check("wd_ack", 32'(a), 32'h1);
    req = '0;
    wait_ready(10);
    req = 4'b0011;
    next_ack(2, a, cyc);
    check("wd_ptr", 32'(a), 32'h2);
    req = '0;

    // Entropy parity.
    ent = 4'b0111;
    step();
    check("ent_odd", 32'(prng_entropy), 32'd1);
    ent = 4'b0011;
    step();
    check("ent_even", 32'(prng_entropy), 32'd0);

    // Randomized handshake traffic with one mid-run reset.
    for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
      ent = N'($urandom);
      prng_random = 16'($urandom);
      if (cyc_i == 1500) begin
        rst_n = 1'b0;
        model_reset();
      end else if (cyc_i == 1502) begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
